// File: rtl/mem_mapper_unit.sv
`default_nettype none
//============================================================================
// Module   : mem_mapper_unit
// Purpose  : Fetch/EX address decode, region-relative translation, access
//            fault flags and a sticky fault-capture register for trap logic.
// Revision : 1.0  initial release
//============================================================================
module mem_mapper_unit #(
    parameter logic [1:0]  XLEN            = 2'b01,
    parameter logic [31:0] INSTR_ROM_START = 32'h0000_0000,
    parameter logic [31:0] INSTR_ROM_END   = 32'h0000_3FFF,
    parameter logic [31:0] DATA_ROM_START  = 32'h0000_4000,
    parameter logic [31:0] DATA_ROM_END    = 32'h0000_7FFF,
    parameter logic [31:0] DATA_RAM_START  = 32'h1000_0000,
    parameter logic [31:0] DATA_RAM_END    = 32'h1000_FFFF,
    parameter logic [31:0] IO_START        = 32'h2000_0000,
    parameter logic [31:0] IO_END          = 32'h2000_00FF,
    localparam int         W               = 1 << (int'(XLEN) + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_fetch_addr,
    input  logic [W-1:0] i_alu_out_e,
    input  logic         i_lw_e,
    input  logic         i_sw_e,
    input  logic         i_fault_clr,
    output logic         o_instr_rom_en,
    output logic         o_data_rom_en,
    output logic         o_data_ram_en,
    output logic         o_io_en,
    output logic [W-1:0] o_fetch_translated_addr,
    output logic [W-1:0] o_ex_translated_addr,
    output logic         o_bad_addr_f,
    output logic         o_bad_addr_load_e,
    output logic         o_bad_addr_store_e,
    output logic         o_fault_valid,
    output logic [1:0]   o_fault_cause,
    output logic [W-1:0] o_fault_addr
);

    localparam logic [1:0] c_CAUSE_NONE  = 2'b00;
    localparam logic [1:0] c_CAUSE_FETCH = 2'b01;
    localparam logic [1:0] c_CAUSE_LOAD  = 2'b10;
    localparam logic [1:0] c_CAUSE_STORE = 2'b11;

    localparam logic [W-1:0] c_IROM_LO = W'(INSTR_ROM_START);
    localparam logic [W-1:0] c_IROM_HI = W'(INSTR_ROM_END);
    localparam logic [W-1:0] c_DROM_LO = W'(DATA_ROM_START);
    localparam logic [W-1:0] c_DROM_HI = W'(DATA_ROM_END);
    localparam logic [W-1:0] c_DRAM_LO = W'(DATA_RAM_START);
    localparam logic [W-1:0] c_DRAM_HI = W'(DATA_RAM_END);
    localparam logic [W-1:0] c_IO_LO   = W'(IO_START);
    localparam logic [W-1:0] c_IO_HI   = W'(IO_END);

    // Offset form of lo <= a <= hi: one subtract and one compare, no
    // degenerate compare against a zero lower bound.
    function automatic logic in_range(input logic [W-1:0] a,
                                      input logic [W-1:0] lo,
                                      input logic [W-1:0] hi);
        return (a - lo) <= (hi - lo);
    endfunction

    logic w_f_irom;
    logic w_e_irom, w_e_drom, w_e_dram, w_e_io, w_e_unmapped;
    logic w_e_sel_drom, w_e_sel_dram, w_e_sel_io;

    always_comb begin
        w_f_irom     = in_range(i_fetch_addr, c_IROM_LO, c_IROM_HI);
        w_e_irom     = in_range(i_alu_out_e, c_IROM_LO, c_IROM_HI);
        w_e_drom     = in_range(i_alu_out_e, c_DROM_LO, c_DROM_HI);
        w_e_dram     = in_range(i_alu_out_e, c_DRAM_LO, c_DRAM_HI);
        w_e_io       = in_range(i_alu_out_e, c_IO_LO,   c_IO_HI);
        w_e_sel_drom = w_e_drom & ~w_e_irom;
        w_e_sel_dram = w_e_dram & ~w_e_irom & ~w_e_drom;
        w_e_sel_io   = w_e_io   & ~w_e_irom & ~w_e_drom & ~w_e_dram;
        w_e_unmapped = ~(w_e_irom | w_e_drom | w_e_dram | w_e_io);
    end

    assign o_instr_rom_en          = w_f_irom;
    assign o_fetch_translated_addr = i_fetch_addr;
    assign o_bad_addr_f            = ~w_f_irom;

    assign o_data_rom_en = w_e_sel_drom;
    assign o_data_ram_en = w_e_sel_dram;
    assign o_io_en       = w_e_sel_io;

    always_comb begin
        o_ex_translated_addr = i_alu_out_e;
        if (w_e_irom)
            o_ex_translated_addr = i_alu_out_e - c_IROM_LO;
        else if (w_e_sel_drom)
            o_ex_translated_addr = i_alu_out_e - c_DROM_LO;
        else if (w_e_sel_dram)
            o_ex_translated_addr = i_alu_out_e - c_DRAM_LO;
        else if (w_e_sel_io)
            o_ex_translated_addr = i_alu_out_e - c_IO_LO;
    end

    assign o_bad_addr_load_e  = i_lw_e & (w_e_irom | w_e_unmapped);
    assign o_bad_addr_store_e = i_sw_e & (w_e_irom | w_e_sel_drom | w_e_unmapped);

    logic         fault_valid_q, fault_valid_d;
    logic [1:0]   fault_cause_q, fault_cause_d;
    logic [W-1:0] fault_addr_q,  fault_addr_d;

    // EX holds the older instruction, so its faults win over fetch.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_cause_d = fault_cause_q;
        fault_addr_d  = fault_addr_q;
        if (i_fault_clr) begin
            fault_valid_d = 1'b0;
            fault_cause_d = c_CAUSE_NONE;
            fault_addr_d  = '0;
        end else if (!fault_valid_q) begin
            if (o_bad_addr_load_e) begin
                fault_valid_d = 1'b1;
                fault_cause_d = c_CAUSE_LOAD;
                fault_addr_d  = i_alu_out_e;
            end else if (o_bad_addr_store_e) begin
                fault_valid_d = 1'b1;
                fault_cause_d = c_CAUSE_STORE;
                fault_addr_d  = i_alu_out_e;
            end else if (o_bad_addr_f) begin
                fault_valid_d = 1'b1;
                fault_cause_d = c_CAUSE_FETCH;
                fault_addr_d  = i_fetch_addr;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fault_valid_q <= 1'b0;
            fault_cause_q <= c_CAUSE_NONE;
            fault_addr_q  <= '0;
        end else begin
            fault_valid_q <= fault_valid_d;
            fault_cause_q <= fault_cause_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign o_fault_valid = fault_valid_q;
    assign o_fault_cause = fault_cause_q;
    assign o_fault_addr  = fault_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_mapper_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_mem_mapper_unit
// Purpose  : Vector table, capture sequences and randomized model check.
// Revision : 1.0  initial release
//============================================================================
module tb_mem_mapper_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_addr, alu_out;
    logic        lw, sw, fault_clr;
    logic        irom_en, drom_en, dram_en, io_en;
    logic [31:0] ftr, etr, fault_addr;
    logic        bad_f, bad_l, bad_s, fault_valid;
    logic [1:0]  fault_cause;

    int checks = 0;
    int fails  = 0;

    mem_mapper_unit dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_fetch_addr            (fetch_addr),
        .i_alu_out_e             (alu_out),
        .i_lw_e                  (lw),
        .i_sw_e                  (sw),
        .i_fault_clr             (fault_clr),
        .o_instr_rom_en          (irom_en),
        .o_data_rom_en           (drom_en),
        .o_data_ram_en           (dram_en),
        .o_io_en                 (io_en),
        .o_fetch_translated_addr (ftr),
        .o_ex_translated_addr    (etr),
        .o_bad_addr_f            (bad_f),
        .o_bad_addr_load_e       (bad_l),
        .o_bad_addr_store_e      (bad_s),
        .o_fault_valid           (fault_valid),
        .o_fault_cause           (fault_cause),
        .o_fault_addr            (fault_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] fa, alu;
        logic        lw, sw;
        logic [3:0]  en;     // {irom, drom, dram, io}
        logic [31:0] etr;
        logic [2:0]  bad;    // {fetch, load, store}
    } vec_t;

    // Reference memory map
    logic [31:0] lo_tab [4] = '{32'h0000_0000, 32'h0000_4000, 32'h1000_0000, 32'h2000_0000};
    logic [31:0] hi_tab [4] = '{32'h0000_3FFF, 32'h0000_7FFF, 32'h1000_FFFF, 32'h2000_00FF};

    // 0 irom, 1 drom, 2 dram, 3 io, 4 unmapped
    function automatic int region(input logic [31:0] a);
        for (int k = 0; k < 4; k++)
            if (a >= lo_tab[k] && a <= hi_tab[k]) return k;
        return 4;
    endfunction

    logic        m_valid;
    logic [1:0]  m_cause;
    logic [31:0] m_addr;

    task automatic check_comb(input string tag);
        int fr, er;
        logic ml, ms, mf;
        fr = region(fetch_addr);
        er = region(alu_out);
        mf = (fr != 0);
        ml = lw && (er == 0 || er == 4);
        ms = sw && (er == 0 || er == 1 || er == 4);
        check({tag, ".en"}, {irom_en, drom_en, dram_en, io_en},
              {fr == 0, er == 1, er == 2, er == 3});
        check({tag, ".ftr"}, ftr, fetch_addr);
        check({tag, ".etr"}, etr, (er == 4) ? alu_out : alu_out - lo_tab[er]);
        check({tag, ".bad"}, {bad_f, bad_l, bad_s}, {mf, ml, ms});
    endtask

    task automatic model_clock();
        int fr, er;
        fr = region(fetch_addr);
        er = region(alu_out);
        if (fault_clr) begin
            m_valid = 0; m_cause = 2'b00; m_addr = '0;
        end else if (!m_valid) begin
            if (lw && (er == 0 || er == 4)) begin
                m_valid = 1; m_cause = 2'b10; m_addr = alu_out;
            end else if (sw && (er == 0 || er == 1 || er == 4)) begin
                m_valid = 1; m_cause = 2'b11; m_addr = alu_out;
            end else if (fr != 0) begin
                m_valid = 1; m_cause = 2'b01; m_addr = fetch_addr;
            end
        end
    endtask

    task automatic check_cap(input string tag, input logic v, input logic [1:0] c, input logic [31:0] a);
        check({tag, ".cap"}, {fault_valid, fault_cause, fault_addr}, {v, c, a});
    endtask

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{32'h0000_0100, 32'h0000_4010, 1, 0, 4'b1100, 32'h0000_0010, 3'b000};
        vecs[1]  = '{32'h0000_0100, 32'h0000_4010, 0, 1, 4'b1100, 32'h0000_0010, 3'b001};
        vecs[2]  = '{32'h0000_0100, 32'h1000_0020, 0, 0, 4'b1010, 32'h0000_0020, 3'b000};
        vecs[3]  = '{32'h0000_0100, 32'h1000_0020, 1, 0, 4'b1010, 32'h0000_0020, 3'b000};
        vecs[4]  = '{32'h0000_0100, 32'h1000_0020, 0, 1, 4'b1010, 32'h0000_0020, 3'b000};
        vecs[5]  = '{32'h0000_0100, 32'h1000_0020, 1, 1, 4'b1010, 32'h0000_0020, 3'b000};
        vecs[6]  = '{32'h0000_0100, 32'h2000_00FF, 1, 1, 4'b1001, 32'h0000_00FF, 3'b000};
        vecs[7]  = '{32'h1000_0000, 32'h0000_3FFF, 1, 1, 4'b0000, 32'h0000_3FFF, 3'b111};
        vecs[8]  = '{32'h0000_3FFC, 32'h3000_0000, 1, 0, 4'b1000, 32'h3000_0000, 3'b010};
        vecs[9]  = '{32'h0000_3FFC, 32'h3000_0000, 0, 1, 4'b1000, 32'h3000_0000, 3'b001};
        vecs[10] = '{32'h0000_3FFC, 32'h3000_0000, 0, 0, 4'b1000, 32'h3000_0000, 3'b000};
        vecs[11] = '{32'h0000_0000, 32'h0000_7FFF, 1, 0, 4'b1100, 32'h0000_3FFF, 3'b000};
        vecs[12] = '{32'h0000_4000, 32'h0000_8000, 1, 1, 4'b0000, 32'h0000_8000, 3'b111};
        vecs[13] = '{32'h0000_3FFF, 32'h1000_FFFF, 0, 1, 4'b1010, 32'h0000_FFFF, 3'b000};
        vecs[14] = '{32'h0000_3FFF, 32'h1001_0000, 1, 0, 4'b1000, 32'h1001_0000, 3'b010};
        vecs[15] = '{32'hFFFF_FFFF, 32'h2000_0100, 0, 1, 4'b0000, 32'h2000_0100, 3'b101};
        vecs[16] = '{32'h0000_0200, 32'h2000_0000, 1, 1, 4'b1001, 32'h0000_0000, 3'b000};

        rst = 1'b1; fetch_addr = '0; alu_out = '0; lw = 0; sw = 0; fault_clr = 0;
        #1;
        check_cap("reset", 1'b0, 2'b00, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fault_clr = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            fetch_addr = vecs[i].fa; alu_out = vecs[i].alu; lw = vecs[i].lw; sw = vecs[i].sw;
            #1;
            check($sformatf("vec%0d.en", i),  {irom_en, drom_en, dram_en, io_en}, vecs[i].en);
            check($sformatf("vec%0d.ftr", i), ftr, vecs[i].fa);
            check($sformatf("vec%0d.etr", i), etr, vecs[i].etr);
            check($sformatf("vec%0d.bad", i), {bad_f, bad_l, bad_s}, vecs[i].bad);
        end

        // Store fault into data ROM is captured one clock later
        @(negedge clk);
        fault_clr = 0; fetch_addr = 32'h100; alu_out = 32'h4010; lw = 0; sw = 1;
        @(posedge clk); #1;
        check_cap("store_cap", 1'b1, 2'b11, 32'h0000_4010);

        // Later faults are ignored while a capture is held
        @(negedge clk);
        fetch_addr = 32'h1000_0000; alu_out = 32'h3000_0000; lw = 1; sw = 0;
        @(posedge clk); #1;
        check_cap("hold", 1'b1, 2'b11, 32'h0000_4010);

        // Clear beats a pending fault in the same cycle
        @(negedge clk);
        fault_clr = 1;
        @(posedge clk); #1;
        check_cap("clr_prio", 1'b0, 2'b00, 32'h0);

        // Load beats store and fetch
        @(negedge clk);
        fault_clr = 0; fetch_addr = 32'h5000; alu_out = 32'h3FFF; lw = 1; sw = 1;
        @(posedge clk); #1;
        check_cap("load_prio", 1'b1, 2'b10, 32'h0000_3FFF);

        // Async reset mid-cycle, combinational path keeps tracking
        @(negedge clk);
        fetch_addr = 32'h100; alu_out = 32'h2000_0010; lw = 0; sw = 1;
        #2 rst = 1'b1;
        #1;
        check_cap("async_rst", 1'b0, 2'b00, 32'h0);
        check("rst_io_en", {io_en, etr}, {1'b1, 32'h10});
        rst = 1'b0;
        @(posedge clk); #1;
        check_cap("no_fault", 1'b0, 2'b00, 32'h0);

        // Store beats fetch
        @(negedge clk);
        fetch_addr = 32'h1000_0000; alu_out = 32'h0000_4000; lw = 1; sw = 1;
        @(posedge clk); #1;
        check_cap("store_prio", 1'b1, 2'b11, 32'h0000_4000);

        // Fetch-only fault
        @(negedge clk);
        fault_clr = 1;
        @(posedge clk);
        @(negedge clk);
        fault_clr = 0; fetch_addr = 32'h1000_0000; alu_out = 32'h1000_0020;
        @(posedge clk); #1;
        check_cap("fetch_cap", 1'b1, 2'b01, 32'h1000_0000);

        @(negedge clk);
        fault_clr = 1;
        @(posedge clk); #1;
        m_valid = 0; m_cause = 2'b00; m_addr = '0;

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a [2];
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                int k;
                k = $urandom_range(0, 4);
                if (k == 4)
                    a[j] = $urandom;
                else
                    a[j] = lo_tab[k] + $urandom_range(0, hi_tab[k] - lo_tab[k] + 32'h20) - 32'h10;
            end
            fetch_addr = ($urandom_range(0, 3) == 0) ? a[0] : ($urandom & 32'h3FFF);
            alu_out    = a[1];
            lw         = $urandom_range(0, 1);
            sw         = $urandom_range(0, 1);
            fault_clr  = ($urandom_range(0, 7) == 0);
            #1;
            check_comb($sformatf("rnd%0d", n));
            @(posedge clk);
            model_clock();
            #1;
            check_cap($sformatf("rnd%0d", n), m_valid, m_cause, m_addr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_mapper_unit.md
Name: mem_mapper_unit

Overview:
- Address decoder and translator between the pipeline and the memory/IO blocks.
- Classifies the fetch PC and the execute-stage ALU address into instruction ROM, data ROM, data RAM or IO.
- Produces per-region enables, region-relative addresses and access-fault flags combinationally.
- Holds a small clocked fault-capture register for the trap logic.

Parameters:
- XLEN, 2'b01 (`XLEN_32b), width code; data width W = 1<<(XLEN+4), so 01 gives 32 and 10 gives 64.
- INSTR_ROM_START, 32'h0000_0000, first instruction ROM byte (inclusive).
- INSTR_ROM_END, 32'h0000_3FFF, last instruction ROM byte (inclusive).
- DATA_ROM_START, 32'h0000_4000, first data ROM byte.
- DATA_ROM_END, 32'h0000_7FFF, last data ROM byte.
- DATA_RAM_START, 32'h1000_0000, first data RAM byte (globals through stack).
- DATA_RAM_END, 32'h1000_FFFF, last data RAM byte.
- IO_START, 32'h2000_0000, first IO byte.
- IO_END, 32'h2000_00FF, last IO byte.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_fetch_addr  in  W  fetch-stage PC
- i_alu_out_e  in  W  execute-stage effective address
- i_lw_e  in  1  execute-stage load
- i_sw_e  in  1  execute-stage store
- i_fault_clr  in  1  clears captured fault
- o_instr_rom_en  out  1  fetch address is in instruction ROM
- o_data_rom_en  out  1  EX address is in data ROM
- o_data_ram_en  out  1  EX address is in data RAM
- o_io_en  out  1  EX address is in IO
- o_fetch_translated_addr  out  W  fetch address passed to instruction ROM
- o_ex_translated_addr  out  W  region-relative EX address
- o_bad_addr_f  out  1  fetch fault
- o_bad_addr_load_e  out  1  load access fault
- o_bad_addr_store_e  out  1  store access fault
- o_fault_valid  out  1  sticky captured-fault flag
- o_fault_cause  out  2  00 none, 01 fetch, 10 load, 11 store
- o_fault_addr  out  W  address that faulted

Behaviour:
- All range tests are unsigned and inclusive at both ends: START <= a <= END.
- Regions are required to be non-overlapping. If they overlap, priority is instr ROM > data ROM > data RAM > IO.
- Decode, translation and fault flags are purely combinational, with zero latency; they do not depend on i_clk or i_rst.
- o_instr_rom_en = fetch address in instruction ROM range.
- o_fetch_translated_addr = i_fetch_addr unchanged; no offset is subtracted.
- o_bad_addr_f = NOT o_instr_rom_en. Fetching from data ROM, RAM, IO or unmapped space always faults.
- EX region enables depend only on i_alu_out_e and are independent of i_lw_e/i_sw_e.
  - At most one of o_data_rom_en, o_data_ram_en, o_io_en is high.
  - All three are low when the address is in instruction ROM or unmapped.
- o_ex_translated_addr = i_alu_out_e minus the start address of the matching region (instr ROM, data ROM, RAM or IO), W-bit wrap arithmetic. If unmapped, it equals i_alu_out_e.
- o_bad_addr_load_e = i_lw_e AND (address in instruction ROM OR unmapped).
- o_bad_addr_store_e = i_sw_e AND (address in instruction ROM OR data ROM OR unmapped).
- With i_lw_e and i_sw_e both high, each fault flag is evaluated independently.
- Fault capture (the only clocked logic):
  - i_rst high, asynchronously: o_fault_valid=0, o_fault_cause=00, o_fault_addr=0.
  - On rising i_clk, if i_fault_clr: the register clears to the reset values. i_fault_clr has priority over a new capture in the same cycle.
  - Else, if o_fault_valid=0 and any bad flag is set: capture with priority load > store > fetch (EX is the older instruction). The captured address is i_alu_out_e for load/store and i_fetch_addr for fetch; o_fault_valid becomes 1.
  - Else the register holds; a captured fault is not overwritten until cleared.
- Reset asserted mid-operation clears only the capture register; the combinational outputs keep tracking their inputs.

Test Plan:
- Fetch 0x0000_0100, ALU 0x0000_4010, lw=1 -> instr_rom_en=1, bad_f=0, data_rom_en=1, ex_trans=0x10, bad_load=0, bad_store=0.
- ALU 0x0000_4010, sw=1 -> bad_store=1, data_rom_en=1; one clock later fault_valid=1, cause=11, fault_addr=0x0000_4010.
- ALU 0x1000_0020 with each of the four lw/sw combinations -> data_ram_en=1, ex_trans=0x20, no EX faults. ALU 0x2000_00FF -> io_en=1, ex_trans=0xFF, no faults.
- Fetch 0x1000_0000 -> instr_rom_en=0, bad_f=1, fetch_trans=0x1000_0000. ALU 0x0000_3FFF with lw=1, sw=1 -> bad_load=1, bad_store=1, all EX enables 0, ex_trans=0x3FFF.
- Unmapped ALU 0x3000_0000 -> no enables, ex_trans=0x3000_0000; bad_load and bad_store high only when lw or sw respectively is high. Boundary addresses 0x0000_7FFF/0x0000_8000 and 0x1000_FFFF/0x1001_0000 switch region at exactly those points.
- Capture then hold: a later fault is ignored while fault_valid=1. Clearing: i_fault_clr clears the register, and async i_rst mid-cycle clears it immediately without waiting for a clock edge.
